// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control path.
// The FSM state encoding is fixed so that other blocks and the display logic see stable values.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10
    } state_t;

    localparam int MAX_SECONDS_DEFAULT = 10;

endpackage

// File: rtl/stopwatch_rise_detect.sv
// Rising-edge detector for a synchronized button level.
// The history flop resets to 1, so a button held through reset produces no edge.
module rise_detect (
    input  logic clk,
    input  logic n_rst,
    input  logic din_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= din_i;
        end
    end

    assign rise_o = din_i & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: run/pause/clear sequencing, seconds counter and optional lap capture.
// Lap capture is compiled in only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int  MAX_SECONDS = MAX_SECONDS_DEFAULT,
    localparam int SEC_W       = $clog2(MAX_SECONDS)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start_stop,
    input  logic             clear,
    input  logic             lap,
    input  logic             second_tick,
    output logic             timer_enable,
    output logic             running,
    output logic [SEC_W-1:0] seconds,
    output logic             wrap,
    output logic [SEC_W-1:0] lap_seconds,
    output logic             lap_valid
);

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(MAX_SECONDS - 1);

    state_t           state_q;
    logic [SEC_W-1:0] seconds_q, seconds_d;
    logic             wrap_q, wrap_d;
    logic             ss_rise, clr_rise, count_en;

    rise_detect u_ss_rise (
        .clk    (clk),
        .n_rst  (n_rst),
        .din_i  (start_stop),
        .rise_o (ss_rise)
    );

    rise_detect u_clr_rise (
        .clk    (clk),
        .n_rst  (n_rst),
        .din_i  (clear),
        .rise_o (clr_rise)
    );

    // Counting keys off the current state, so a tick coincident with a pause still counts.
    assign count_en = (state_q == RUNNING) && second_tick;

    always_comb begin
        seconds_d = seconds_q;
        wrap_d    = 1'b0;
        if (count_en) begin
            if (seconds_q == SEC_LAST) begin
                seconds_d = '0;
                wrap_d    = 1'b1;
            end else begin
                seconds_d = seconds_q + SEC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            seconds_q <= '0;
            wrap_q    <= 1'b0;
        end else if (clr_rise) begin
            state_q   <= IDLE;
            seconds_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            seconds_q <= seconds_d;
            wrap_q    <= wrap_d;
            if (ss_rise) begin
                case (state_q)
                    IDLE:    state_q <= RUNNING;
                    RUNNING: state_q <= PAUSED;
                    PAUSED:  state_q <= RUNNING;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign timer_enable = (state_q == RUNNING);
    assign running      = (state_q == RUNNING);
    assign seconds      = seconds_q;
    assign wrap         = wrap_q;

`ifdef STOPWATCH_LAP_EN
    logic [SEC_W-1:0] lap_seconds_q;
    logic             lap_valid_q;
    logic             lap_rise;

    rise_detect u_lap_rise (
        .clk    (clk),
        .n_rst  (n_rst),
        .din_i  (lap),
        .rise_o (lap_rise)
    );

    // The snapshot takes the pre-update count, even when a tick lands in the same cycle.
    always_ff @(posedge clk) begin
        if (!n_rst || clr_rise) begin
            lap_seconds_q <= '0;
            lap_valid_q   <= 1'b0;
        end else if (lap_rise && (state_q == RUNNING)) begin
            lap_seconds_q <= seconds_q;
            lap_valid_q   <= 1'b1;
        end
    end

    assign lap_seconds = lap_seconds_q;
    assign lap_valid   = lap_valid_q;
`else
    logic unused_lap;
    assign unused_lap  = lap;
    assign lap_seconds = '0;
    assign lap_valid   = 1'b0;
`endif

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control FSM that sequences the `timer` block for the stopwatch. It turns synchronized start/stop, clear and lap button levels into run/pause/clear control, and drives `timer.enable`. It counts `timer.second_tick` pulses into an elapsed-seconds value and can capture a lap snapshot. It sits between the button synchronizers and the `timer`/display logic.

## Interface
- `MAX_SECONDS`, default 10: count modulus; seconds run from 0 to MAX_SECONDS-1, then wrap. Must be ≥ 2.
- `SEC_W` (localparam): `$clog2(MAX_SECONDS)`, which is 4 for the default.
- `clk`  in  1  system clock; one clock domain.
- `n_rst`  in  1  reset; synchronous, active-low.
- `start_stop`  in  1  synchronized button level. A rising edge toggles run/pause.
- `clear`  in  1  synchronized button level. A rising edge returns the block to IDLE.
- `lap`  in  1  synchronized button level. A rising edge captures the lap value.
- `second_tick`  in  1  one-cycle pulse from `timer`.
- `timer_enable`  out  1  drives `timer.enable`.
- `running`  out  1  high while in RUNNING.
- `seconds`  out  SEC_W  elapsed seconds.
- `wrap`  out  1  one-cycle pulse when `seconds` wraps from MAX_SECONDS-1 to 0.
- `lap_seconds`  out  SEC_W  captured lap value.
- `lap_valid`  out  1  high once a lap has been captured; cleared by `clear`.

## Operation
- States: IDLE, RUNNING, PAUSED.
- Edge detection: a rising edge is `in & ~prev`. `prev` registers reset to 1, so a button held through reset produces no edge.
- Transitions on a `start_stop` edge:
  - IDLE → RUNNING
  - RUNNING → PAUSED
  - PAUSED → RUNNING
- A `clear` edge forces IDLE from any state. It also sets `seconds` to 0, `lap_seconds` to 0 and `lap_valid` to 0.
- `clear` beats `start_stop` when both edges occur in the same cycle.
- Counting happens only when the current state is RUNNING and `second_tick` is 1:
  - If `seconds == MAX_SECONDS-1`, `seconds` becomes 0 and `wrap` is 1 next cycle.
  - Otherwise `seconds` increments by 1.
- Ticks seen in IDLE or PAUSED are ignored.
- Tick and pause in the same cycle: the tick is counted, because the current state is still RUNNING.
- Tick and `clear` in the same cycle: `clear` wins, and `seconds` becomes 0 with no `wrap`.
- `timer_enable` and `running` are decoded from the registered state, so both equal (state == RUNNING).
- Lap (only when `STOPWATCH_LAP_EN` is compiled in):
  - A `lap` edge while RUNNING sets `lap_seconds` to the current pre-update `seconds` and sets `lap_valid` to 1.
  - Lap edges in other states are ignored.
  - A new lap overwrites the previous one.
  - `clear` beats `lap` in the same cycle.

## Timing
- Reset values: state IDLE, `timer_enable` 0, `running` 0, `seconds` 0, `wrap` 0, `lap_seconds` 0, `lap_valid` 0.
- All outputs are registered or decoded only from registers; there is no combinational input-to-output path.
- Button edges: an input sampled high at clock edge k with `prev` = 0 updates the state at edge k. `timer_enable` is therefore valid right after edge k, one cycle after the input rose.
- Ticks: a `second_tick` sampled at edge k updates `seconds` at edge k, with 1 cycle latency.
- `wrap` is high for exactly the cycle following the wrap edge.
- Reset mid-run: asserting `n_rst` low at any edge forces all reset values at that edge, and any pending edge or tick is lost.

## Configuration
- `STOPWATCH_LAP_EN`
  - Defined: lap edge detection, the `lap_seconds` register and `lap_valid` are implemented as described above.
  - Undefined: the lap logic is removed, `lap` is ignored, and `lap_seconds` and `lap_valid` are tied to 0. The ports remain, so the port list is unchanged.

## Structure
- `stopwatch_pkg` holds:
  - `state_t` enum: IDLE = 2'b00, RUNNING = 2'b01, PAUSED = 2'b10.
  - Default `MAX_SECONDS` constant, shared with `timer` instantiations.
- Sub-module `rise_detect`: one flop plus an AND, with the `prev` register resetting to 1. It is instantiated once per button input.
- The FSM, seconds counter and lap register live in `stopwatch_ctrl`.

## Test plan
1. Reset, then idle 10 cycles with `second_tick` pulsed → `timer_enable` = 0, `seconds` = 0, all outputs at reset values.
2. `start_stop` edge, then 3 ticks, then `start_stop` edge, then 2 ticks → `timer_enable` rises 1 cycle after the edge, `seconds` = 3 and held, state PAUSED.
3. Run with MAX_SECONDS = 10 and apply 10 ticks → `seconds` goes 1…9 and then 0, with `wrap` high for exactly one cycle after the 10th tick.
4. Tick and `start_stop` edge in the same cycle while RUNNING at `seconds` = 4 → `seconds` = 5 and state PAUSED. Tick, `clear` and `start_stop` all in the same cycle → `seconds` = 0, state IDLE, no `wrap`.
5. `STOPWATCH_LAP_EN`: RUNNING at `seconds` = 6, `lap` edge coincident with a tick → `lap_seconds` = 6, `lap_valid` = 1, `seconds` = 7. A lap edge in PAUSED leaves `lap_seconds` unchanged. `clear` → `lap_valid` = 0.
6. `start_stop` held high through reset release, then pulse `n_rst` low mid-run at `seconds` = 5 → no spurious start after the first reset, and all outputs return to reset values after the second.
